// File: rtl/ram_port_arbiter.sv
// Arbitrated front end sharing one single-port byte RAM controller among NUM_REQ requesters.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ram_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [7:0]                rsp_rdata,
    output logic                      busy,
    output logic                      mem_read_en,
    output logic                      mem_write_en,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [7:0]                mem_data_in,
    input  logic [7:0]                mem_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [PW-1:0]       r_cmd_port;
    logic                r_cmd_we;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [7:0]          r_cmd_wdata;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PW-1:0]       w_grant_idx;
    logic                w_accept;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [7:0]          w_sel_wdata;
    logic [NUM_REQ-1:0]  w_port_oh;

`ifdef RAM_ARB_RR_EN
    logic [PW-1:0]       r_prio;

    // Search starts at the port after the last winner; the outer loop selects the start offset.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        for (int unsigned p = 0; p < NUM_REQ; p++) begin
            if (r_prio == PW'(p)) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if ((w_grant == '0) && req_valid[(p + i) % NUM_REQ]) begin
                        w_grant[(p + i) % NUM_REQ] = 1'b1;
                        w_grant_idx                = PW'((p + i) % NUM_REQ);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= '0;
        end else if (w_accept) begin
            r_prio <= (w_grant_idx == PW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((w_grant == '0) && req_valid[i]) begin
                w_grant[i]  = 1'b1;
                w_grant_idx = PW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_port_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_port_oh[i] = (r_cmd_port == PW'(i));
        end
    end

    assign w_accept = (r_state == S_IDLE) && (w_grant != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = '0;
        busy         = 1'b1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_address  = r_cmd_addr;
        mem_data_in  = r_cmd_wdata;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // Held at zero while reset is applied even though the state already reads IDLE.
                req_ready = rst_n ? w_grant : '0;
                if (w_accept) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_write_en = r_cmd_we;
                mem_read_en  = ~r_cmd_we;
                w_next       = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_CAPT;
            end
            S_CAPT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_port  <= '0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_accept) begin
            r_cmd_port  <= w_grant_idx;
            r_cmd_we    <= w_sel_we;
            r_cmd_addr  <= w_sel_addr;
            r_cmd_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (r_state == S_CAPT) begin
                rsp_valid <= w_port_oh;
                if (!r_cmd_we) begin
                    rsp_rdata <= mem_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: cycle-level reference model plus directed and random stimulus.
// Expectations follow RAM_ARB_RR_EN when the bench is built with it defined.
module tb_ram_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*8-1:0]      req_wdata = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [7:0]                rsp_rdata;
    logic                      busy;
    logic                      mem_read_en;
    logic                      mem_write_en;
    logic [ADDR_W-1:0]         mem_address;
    logic [7:0]                mem_data_in;
    logic [7:0]                mem_data_out;

    always #5 clk = ~clk;

    ram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Stand-in RAM controller: registered read data, held until the next read.
    logic [7:0] ram [256] = '{default: 8'h00};
    logic [7:0] ram_q = 8'h00;
    assign mem_data_out = ram_q;
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address] <= mem_data_in;
        if (mem_read_en)  ram_q <= ram[mem_address];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_acc = 0;
    logic [7:0] ref_mem [256];

    // Model: age = cycles since the accept edge (-1 when nothing is in flight).
    int         age = -1;
    int         act_port = 0;
    logic       act_we = 1'b0;
    logic [7:0] act_addr = '0;
    logic [7:0] act_wdata = '0;
    logic [7:0] act_rd = '0;
    logic [7:0] exp_rdata = '0;
    int         prio = 0;
    logic       prev_en = 1'b0;

    int         g_port[$];
    int         g_cyc[$];
    logic [7:0] last_rsp = '0;
    int         last_rsp_port = -1;
    int         last_rsp_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int k);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_grant();
        if (!(age == -1 || age == 4)) return '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef RAM_ARB_RR_EN
            if (req_valid[(prio + i) % NUM_REQ]) return oh((prio + i) % NUM_REQ);
`else
            if (req_valid[i]) return oh(i);
`endif
        end
        return '0;
    endfunction

    task automatic load(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        req_valid[p]             = 1'b1;
        req_we[p]                = we;
        req_addr[p*ADDR_W +: ADDR_W] = a;
        req_wdata[p*8 +: 8]      = d;
    endtask

    // One clock: check at negedge against the model, advance the model, return at posedge+1.
    task automatic cycle();
        logic [NUM_REQ-1:0] g;
        int k;
        @(negedge clk);
        g = exp_grant();
        chk("req_ready", req_ready, g);
        chk("busy", busy, (age >= 1 && age <= 3));
        chk("mem_write_en", mem_write_en, (age == 1 && act_we));
        chk("mem_read_en", mem_read_en, (age == 1 && !act_we));
        chk("en_both", mem_read_en & mem_write_en, 0);
        chk("en_consec", prev_en & (mem_read_en | mem_write_en), 0);
        chk("rsp_valid", rsp_valid, (age == 4) ? oh(act_port) : '0);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        if (age >= 1 && age <= 3) begin
            chk("mem_address", mem_address, act_addr);
            chk("mem_data_in", mem_data_in, act_wdata);
        end
        prev_en = mem_read_en | mem_write_en;
        if (req_ready != '0) begin
            g_port.push_back(idx_of(req_ready));
            g_cyc.push_back(cyc);
        end
        if (rsp_valid != '0) begin
            last_rsp      = rsp_rdata;
            last_rsp_port = idx_of(rsp_valid);
            last_rsp_cyc  = cyc;
        end
        k = idx_of(g);
        if (k >= 0) begin
            act_port  = k;
            act_we    = req_we[k];
            act_addr  = req_addr[k*ADDR_W +: ADDR_W];
            act_wdata = req_wdata[k*8 +: 8];
            act_rd    = ref_mem[act_addr];
            if (act_we) ref_mem[act_addr] = act_wdata;
            prio  = (k + 1) % NUM_REQ;
            age   = 1;
            n_acc++;
        end else if (age >= 1) begin
            age++;
            if (age > 4) age = -1;
        end
        if (age == 4 && !act_we) exp_rdata = act_rd;
        @(posedge clk);
        #1;
        if (k >= 0) req_valid[k] = 1'b0;
        cyc++;
    endtask

    task automatic drain();
        int guard = 0;
        while ((req_valid != '0 || age != -1) && guard < 100) begin
            cycle();
            guard++;
        end
        chk("drain_bound", guard < 100, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, mem_read_en, 0);
        chk({tag, "_wr_en"}, mem_write_en, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_din"}, mem_data_in, 0);
    endtask

    // Entered and left at posedge+1; no requests may be pending at release.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(tag);
        age = -1; exp_rdata = '0; prio = 0; prev_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_hold_rsp"}, rsp_valid, 0);
            chk({tag, "_hold_busy"}, busy, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        int start;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then read on port 0
        g_cyc.delete(); g_port.delete();
        load(0, 1'b1, 8'h10, 8'hA5);
        drain();
        chk("wr_ack_port", last_rsp_port, 0);
        chk("wr_latency", last_rsp_cyc - g_cyc[0], 4);
        g_cyc.delete();
        load(0, 1'b0, 8'h10, 8'h00);
        drain();
        chk("rd_data", last_rsp, 8'hA5);
        chk("rd_latency", last_rsp_cyc - g_cyc[0], 4);

        // Contention: both ports read continuously, then stop refilling
        pulse_reset("rst1");
        g_cyc.delete(); g_port.delete();
        load(0, 1'b0, 8'h20, 8'h00);
        load(1, 1'b0, 8'h21, 8'h00);
        guard = 0;
        while (g_port.size() < 5 && guard < 60) begin
            cycle();
            guard++;
            if (g_port.size() < 4) begin
                if (!req_valid[0]) load(0, 1'b0, 8'h20, 8'h00);
                if (!req_valid[1]) load(1, 1'b0, 8'h21, 8'h00);
            end
        end
        chk("contend_bound", g_port.size(), 5);
        if (g_port.size() == 5) begin
`ifdef RAM_ARB_RR_EN
            chk("rr_g0", g_port[0], 0);
            chk("rr_g1", g_port[1], 1);
            chk("rr_g2", g_port[2], 0);
            chk("rr_g3", g_port[3], 1);
            chk("rr_g4", g_port[4], 0);
`else
            chk("fx_g0", g_port[0], 0);
            chk("fx_g1", g_port[1], 0);
            chk("fx_g2", g_port[2], 0);
            chk("fx_g3", g_port[3], 0);
            chk("fx_g4", g_port[4], 1);
`endif
            for (int i = 1; i < 5; i++) chk("grant_spacing", g_cyc[i] - g_cyc[i-1], 4);
        end
        drain();

        // Cross-port coherence: port 1 writes, port 0 reads queued behind it
        g_port.delete();
        load(1, 1'b1, 8'hFF, 8'h3C);
        cycle();
        load(0, 1'b0, 8'hFF, 8'h00);
        drain();
        chk("coh_data", last_rsp, 8'h3C);
        chk("coh_port", last_rsp_port, 0);

        // Reset while a read is in EXEC
        last_rsp_port = -1;
        load(0, 1'b0, 8'h10, 8'h00);
        cycle();
        cycle();
        chk("exec_reached", age, 2);
        pulse_reset("rst2");
        chk("dropped_rsp", last_rsp_port, -1);
        g_cyc.delete();
        load(1, 1'b0, 8'h10, 8'h00);
        drain();
        chk("post_rst_data", last_rsp, 8'hA5);
        chk("post_rst_port", last_rsp_port, 1);
        chk("post_rst_latency", last_rsp_cyc - g_cyc[0], 4);

        // Random commands with full per-cycle pin protocol checking
        start = n_acc;
        guard = 0;
        while ((n_acc - start) < 50 && guard < 2000) begin
            for (int p = 0; p < NUM_REQ; p++) begin
                if (!req_valid[p] && ($urandom_range(0, 1) == 1)) begin
                    load(p, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                         8'($urandom));
                end
            end
            cycle();
            guard++;
        end
        chk("rand_bound", (n_acc - start) >= 50, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
